// File: rtl/imm_enc_if.sv
// Field-set in / instruction word out handshake bundle for the RV32 immediate encoder.
`timescale 1ns/1ps
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  out_fmt;
  logic        out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_fmt, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_fmt, out_err
  );
endinterface

// File: rtl/imm_enc.sv
// RV32 instruction packer: two-stage valid/ready pipeline that places register, function
// and immediate fields by opcode format and flags unrepresentable immediates.
`timescale 1ns/1ps
module imm_enc #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_enc_if.slave             bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5,
    FMT_X  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } fields_t;

  fields_t         in_fields_c;
  fields_t         s1_q;
  logic            s1_valid;
  logic            s2_load_c;
  logic            accept_c;
  fmt_e            fmt_c;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] instr_c;
  logic            err_c;

  assign in_fields_c = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                         rs2: bus.in_rs2, funct3: bus.in_funct3, funct7: bus.in_funct7,
                         imm: bus.in_imm};

  // Stage 2 refills whenever its word is gone or leaving; stage 1 follows it.
  assign s2_load_c    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rst_n && (!s1_valid || s2_load_c);
  assign accept_c     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_q     <= in_fields_c;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Opcode to instruction format.
  always_comb begin
    fmt_c = FMT_X;
    case (s1_q.opcode)
      7'b0000011, 7'b0001111, 7'b0011011,
      7'b1100111, 7'b1110011, 7'b0010011: fmt_c = FMT_I;
      7'b0100011:                         fmt_c = FMT_S;
      7'b1100011:                         fmt_c = FMT_SB;
      7'b1101111:                         fmt_c = FMT_UJ;
      7'b0010111, 7'b0110111:             fmt_c = FMT_U;
      7'b0110011, 7'b0111011:             fmt_c = FMT_R;
      default:                            fmt_c = FMT_X;
    endcase
  end

  assign imm_c = s1_q.imm;

  // Field packing; the word is built from truncated immediate bits even when flagged.
  always_comb begin
    instr_c = '0;
    err_c   = 1'b0;
    case (fmt_c)
      FMT_R: begin
        instr_c = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      end
      FMT_I: begin
        instr_c = {imm_c[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
        err_c   = imm_c != {{20{imm_c[11]}}, imm_c[11:0]};
      end
      FMT_S: begin
        instr_c = {imm_c[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3, imm_c[4:0], s1_q.opcode};
        err_c   = imm_c != {{20{imm_c[11]}}, imm_c[11:0]};
      end
      FMT_SB: begin
        instr_c = {imm_c[12], imm_c[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                   imm_c[4:1], imm_c[11], s1_q.opcode};
        err_c   = imm_c[0] || (imm_c != {{19{imm_c[12]}}, imm_c[12:0]});
      end
      FMT_U: begin
        instr_c = {imm_c[31:12], s1_q.rd, s1_q.opcode};
        err_c   = |imm_c[11:0];
      end
      FMT_UJ: begin
        instr_c = {imm_c[20], imm_c[10:1], imm_c[11], imm_c[19:12], s1_q.rd, s1_q.opcode};
        err_c   = imm_c[0] || (imm_c != {{11{imm_c[20]}}, imm_c[20:0]});
      end
      default: begin
        instr_c = {25'b0, s1_q.opcode};
        err_c   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_fmt   <= 3'd0;
      bus.out_err   <= 1'b0;
    end else if (s2_load_c) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_instr <= instr_c;
        bus.out_fmt   <= fmt_c;
        bus.out_err   <= err_c;
      end
    end
  end

  // Saturating count of flagged words actually taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_err && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Directed bench for imm_enc: encodings, error flags, latency, backpressure,
// counter saturation and mid-flight reset.
`timescale 1ns/1ps
module tb_imm_enc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] exp_cnt = 16'd0;
  int          total = 0;
  int          bad = 0;

  imm_enc_if a();
  imm_enc_if b();

  imm_enc #(.ERR_CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(a.slave), .err_cnt(cnt_a));
  imm_enc #(.ERR_CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b.slave), .err_cnt(cnt_b));

  always #5 clk = ~clk;

  task automatic drive_a(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    a.in_valid = 1'b1; a.in_opcode = op; a.in_rd = rd; a.in_rs1 = rs1; a.in_rs2 = rs2;
    a.in_funct3 = f3; a.in_funct7 = f7; a.in_imm = imm;
  endtask

  // Push one word through an otherwise idle pipe; lat counts edges from accept to out_valid.
  task automatic run_word(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm, output logic [35:0] obs, output int lat);
    int guard;
    drive_a(op, rd, rs1, rs2, f3, f7, imm);
    a.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!a.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    lat = 1;
    while (!a.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    obs = {a.out_instr, a.out_fmt, a.out_err};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({a.out_valid, a.out_err, a.out_fmt, a.out_instr, cnt_a, a.in_ready} !== 54'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b err=%b fmt=%0d instr=%h cnt=%0d in_ready=%b want all 0",
               a.out_valid, a.out_err, a.out_fmt, a.out_instr, cnt_a, a.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    logic [35:0] obs; int lat;
    run_word(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, obs, lat);
    total++;
    if (obs !== {32'hFFF0_0093, 3'd1, 1'b0}) begin
      bad++; $display("FAIL addi_m1: got=%h want=%h", obs, {32'hFFF0_0093, 3'd1, 1'b0});
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL latency: got=%0d want=2", lat); end
    run_word(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h8000_0093, 3'd1, 1'b1}) begin
      bad++; $display("FAIL addi_800: got=%h want=%h", obs, {32'h8000_0093, 3'd1, 1'b1});
    end
    total++;
    if (cnt_a !== exp_cnt) begin bad++; $display("FAIL cnt_addi: got=%0d want=%0d", cnt_a, exp_cnt); end
  endtask

  task automatic test_branch();
    logic [35:0] obs; int lat;
    run_word(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, obs, lat);
    total++;
    if (obs !== {32'h0000_0463, 3'd3, 1'b0}) begin
      bad++; $display("FAIL beq_8: got=%h want=%h", obs, {32'h0000_0463, 3'd3, 1'b0});
    end
    run_word(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h0000_0363, 3'd3, 1'b1}) begin
      bad++; $display("FAIL beq_7: got=%h want=%h", obs, {32'h0000_0363, 3'd3, 1'b1});
    end
    total++;
    if (cnt_a !== exp_cnt) begin bad++; $display("FAIL cnt_beq: got=%0d want=%0d", cnt_a, exp_cnt); end
    run_word(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h8000_0063, 3'd3, 1'b1}) begin
      bad++; $display("FAIL beq_range: got=%h want=%h", obs, {32'h8000_0063, 3'd3, 1'b1});
    end
  endtask

  task automatic test_jal_lui();
    logic [35:0] obs; int lat;
    run_word(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, obs, lat);
    total++;
    if (obs !== {32'h0010_00EF, 3'd5, 1'b0}) begin
      bad++; $display("FAIL jal_800: got=%h want=%h", obs, {32'h0010_00EF, 3'd5, 1'b0});
    end
    run_word(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h8000_00EF, 3'd5, 1'b1}) begin
      bad++; $display("FAIL jal_range: got=%h want=%h", obs, {32'h8000_00EF, 3'd5, 1'b1});
    end
    run_word(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, obs, lat);
    total++;
    if (obs !== {32'h1234_52B7, 3'd4, 1'b0}) begin
      bad++; $display("FAIL lui: got=%h want=%h", obs, {32'h1234_52B7, 3'd4, 1'b0});
    end
    run_word(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h1234_52B7, 3'd4, 1'b1}) begin
      bad++; $display("FAIL lui_low: got=%h want=%h", obs, {32'h1234_52B7, 3'd4, 1'b1});
    end
  endtask

  task automatic test_rs_types();
    logic [35:0] obs; int lat;
    run_word(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, obs, lat);
    total++;
    if (obs !== {32'h0020_81B3, 3'd0, 1'b0}) begin
      bad++; $display("FAIL add_r: got=%h want=%h", obs, {32'h0020_81B3, 3'd0, 1'b0});
    end
    run_word(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, obs, lat);
    total++;
    if (obs !== {32'hFE20_AE23, 3'd2, 1'b0}) begin
      bad++; $display("FAIL sw_m4: got=%h want=%h", obs, {32'hFE20_AE23, 3'd2, 1'b0});
    end
    run_word(7'b1111111, 5'd5, 5'd7, 5'd9, 3'd3, 7'd1, 32'h0000_0004, obs, lat);
    exp_cnt++;
    total++;
    if (obs !== {32'h0000_007F, 3'd7, 1'b1}) begin
      bad++; $display("FAIL unknown_op: got=%h want=%h", obs, {32'h0000_007F, 3'd7, 1'b1});
    end
    total++;
    if (cnt_a !== exp_cnt) begin bad++; $display("FAIL cnt_total: got=%0d want=%0d", cnt_a, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expw [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
    logic [31:0] got [4];
    int i = 0, k = 0, stalls = 0, first = -1, last = -1;
    a.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (i < 4) drive_a(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      else a.in_valid = 1'b0;
      #1;
      if (a.in_valid && !a.in_ready) stalls++;
      if (a.out_valid && k < 4) begin
        got[k] = a.out_instr; k++;
        if (first < 0) first = c;
        last = c;
      end
      if (a.in_valid && a.in_ready) i++;
      @(posedge clk); #1;
    end
    total++;
    if (stalls !== 0 || k !== 4 || last - first !== 3) begin
      bad++; $display("FAIL b2b_rate: got stalls=%0d words=%0d span=%0d want 0/4/3",
                      stalls, k, last - first);
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== expw[j]) begin bad++; $display("FAIL b2b_word%0d: got=%h want=%h", j, got[j], expw[j]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expw [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
    logic [31:0] got [4];
    int i = 0, k = 0, unstable = 0;
    a.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive_a(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      #1;
      if (c >= 2 && (!a.out_valid || a.out_instr !== expw[0])) unstable++;
      if (a.in_ready) i++;
      @(posedge clk); #1;
    end
    total++;
    if (i !== 2 || a.in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_accepts: got accepts=%0d in_ready=%b want 2/0", i, a.in_ready);
    end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got unstable=%0d want 0", unstable); end
    a.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (i < 4) drive_a(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      else a.in_valid = 1'b0;
      #1;
      if (a.out_valid) begin
        if (k < 4) got[k] = a.out_instr;
        k++;
      end
      if (a.in_valid && a.in_ready) i++;
      @(posedge clk); #1;
    end
    total++;
    if (k !== 4) begin bad++; $display("FAIL bp_count: got=%0d want=4", k); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== expw[j]) begin bad++; $display("FAIL bp_word%0d: got=%h want=%h", j, got[j], expw[j]); end
    end
  endtask

  task automatic test_saturation();
    b.out_ready = 1'b1;
    b.in_opcode = 7'b1111111;
    b.in_valid  = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    b.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_cnt: got=%0d want=3", cnt_b); end
  endtask

  task automatic test_reset_midflight();
    logic [35:0] obs; int lat;
    b.out_ready = 1'b0;
    b.in_opcode = 7'b0010011;
    b.in_imm    = 32'd5;
    b.in_valid  = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (b.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: got out_valid=%b want 1", b.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({b.out_valid, cnt_b, b.in_ready, b.out_instr} !== 36'd0) begin
      bad++; $display("FAIL rst_async: got valid=%b cnt=%0d in_ready=%b instr=%h want 0",
                      b.out_valid, cnt_b, b.in_ready, b.out_instr);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rst_hold: got out_valid=%b want 0", b.out_valid); end
    b.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_word(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, obs, lat);
    total++;
    if (lat !== 2 || obs !== {32'hFFF0_0093, 3'd1, 1'b0}) begin
      bad++; $display("FAIL rst_first: got lat=%0d obs=%h want 2/%h", lat, obs, {32'hFFF0_0093, 3'd1, 1'b0});
    end
    total++;
    if (cnt_a !== 16'd0) begin bad++; $display("FAIL rst_cnt: got=%0d want=0", cnt_a); end
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_opcode = '0; a.in_rd = '0; a.in_rs1 = '0; a.in_rs2 = '0;
    a.in_funct3 = '0; a.in_funct7 = '0; a.in_imm = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_opcode = '0; b.in_rd = '0; b.in_rs1 = '0; b.in_rs2 = '0;
    b.in_funct3 = '0; b.in_funct7 = '0; b.in_imm = '0; b.out_ready = 1'b0;
    test_reset();
    test_itype();
    test_branch();
    test_jal_lui();
    test_rs_types();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/imm_enc.md
IMM_ENC -- requirements
Module: imm_enc

Interface
REQ-001 The block SHALL have one parameter: ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream has a field set to encode.
REQ-006 in_ready  output  1  block accepts the field set this cycle.
REQ-007 in_opcode  input  7  instruction opcode; selects the format.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-010 in_imm  input  32  sign-extended byte-offset immediate.
REQ-011 out_valid  output  1  out_instr, out_err and out_fmt are valid.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_instr  output  32  packed RV32 instruction word.
REQ-014 out_fmt  output  3  0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ, 7=unknown.
REQ-015 out_err  output  1  the immediate is not representable, or the opcode is unknown.
REQ-016 err_cnt  output  ERR_CNT_W  count of errored words delivered.

Function
REQ-017 Format decode SHALL be: I = 0000011, 0001111, 0011011, 1100111, 1110011, 0010011; S = 0100011; SB = 1100011; UJ = 1101111; U = 0010111, 0110111; R = 0110011, 0111011; any other opcode = unknown.
REQ-018 Field placement SHALL be: opcode [6:0]; rd [11:7] for R/I/U/UJ; funct3 [14:12] for R/I/S/SB; rs1 [19:15] for R/I/S/SB; rs2 [24:20] for R/S/SB; funct7 [31:25] for R only; all unused bits SHALL be 0.
REQ-019 Immediate placement SHALL be:
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- SB: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U: [31:12]=imm[31:12].
- UJ: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-020 out_err SHALL be set when any of the following holds:
- I/S: imm differs from the sign-extension of imm[11:0].
- SB: imm[0]=1, or imm differs from the sign-extension of imm[12:0].
- UJ: imm[0]=1, or imm differs from the sign-extension of imm[20:0].
- U: imm[11:0] is non-zero.
- The opcode is unknown.
R-format words SHALL ignore in_imm and never set out_err.
REQ-021 On error, the word SHALL still be packed from the truncated immediate bits per REQ-019. For an unknown opcode, out_instr SHALL be {25'b0, in_opcode}.
REQ-022 The datapath SHALL be a two-stage valid/ready pipeline:
- Stage 1 registers the input fields.
- Stage 2 registers out_instr, out_fmt and out_err.
- Latency SHALL be 2 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
- Sustained throughput SHALL be 1 word per cycle.
REQ-023 Stage 2 SHALL load when it is empty or out_ready=1. Stage 1 SHALL advance when stage 2 loads. in_ready SHALL be !s1_valid || stage-2 load, so in_ready depends combinationally on out_ready.
REQ-024 While out_valid=1 and out_ready=0, out_instr, out_fmt and out_err SHALL hold stable. No word SHALL be dropped or duplicated.
REQ-025 err_cnt SHALL increment by 1 on each out_valid&&out_ready&&out_err cycle, and SHALL saturate at all-ones.

Reset
REQ-026 While rst_n=0, the block SHALL force:
- both stage valids, out_valid, out_err and err_cnt to 0;
- out_instr to 32'h0;
- out_fmt to 0.
The block SHALL accept no input during reset.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight words immediately. The first accept after reset SHALL appear at out_valid 2 cycles later.

Verification
REQ-028 addi x1,x0,-1: opcode 0010011, rd=1, f3=0, rs1=0, imm=FFFFFFFF -> out_instr=FFF00093, fmt=1, err=0, 2 cycles after accept.
REQ-029 beq x0,x0,+8: opcode 1100011, imm=8 -> 00000463, err=0. The same with imm=7 -> err=1 and err_cnt increments on handshake.
REQ-030 jal x1,+2048: opcode 1101111, rd=1, imm=00000800 -> 001000EF. lui x5: opcode 0110111, rd=5, imm=12345000 -> 123452B7.
REQ-031 addi with imm=00000800 -> out_instr=80000093, err=1. Opcode 1111111 -> out_instr=0000007F, fmt=7, err=1.
REQ-032 Backpressure: stream 4 back-to-back words with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts and outputs stay stable; on release all 4 words emerge in order, with no loss.
REQ-033 Saturation and reset: with ERR_CNT_W=2, deliver 5 errored words -> err_cnt=3. Assert rst_n low with 2 words in flight -> out_valid=0 and err_cnt=0 in the same cycle.
